axil_csr_bank: RTL and testbench

Parametrised AXI4-Lite control/status register bank for the ternary CNN accelerator. It replaces the fixed 4 x 32-bit read/write CSR slave with a set of configurable read/write config registers, read-only status registers, and a control register that issues a self-clearing start pulse. It also provides a write-1-to-clear interrupt register with an enable. It sits between the PS AXI interconnect and the accelerator core.

---
 rtl/csr_bank_pkg.sv | 32 +++
 rtl/csr_strb_reg.sv | 36 +++
 rtl/axil_csr_bank.sv | 255 +++++++++++++++++++++++++
 tb/tb_axil_csr_bank.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_bank_pkg.sv
// Shared constants for the AXI4-Lite CSR bank: register map, CTRL bit positions,
// response codes and FSM state encodings.
package csr_bank_pkg;

    localparam int unsigned CTRL_IDX = 0;
    localparam int unsigned CFG_BASE = 1;

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_HAVE_AW = 2'd1;
    localparam logic [1:0] W_HAVE_W  = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    function automatic int unsigned stat_base(input int unsigned num_cfg);
        return CFG_BASE + num_cfg;
    endfunction

    // IRQ_STATUS sits directly after the last status register.
    function automatic int unsigned irq_idx(input int unsigned num_cfg,
                                            input int unsigned num_stat);
        return CFG_BASE + num_cfg + num_stat;
    endfunction

endpackage

// File: rtl/csr_strb_reg.sv
// Single register with per-byte write strobes and asynchronous active-low reset.
module csr_strb_reg #(
    parameter int unsigned DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] strb_i,
    input  logic [DataWidth-1:0]   d_i,
    output logic [DataWidth-1:0]   q_o
);

    logic [DataWidth-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (we_i) begin
            for (int unsigned b = 0; b < DataWidth / 8; b++) begin
                if (strb_i[b]) begin
                    q_d[b*8 +: 8] = d_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/axil_csr_bank.sv
// AXI4-Lite CSR bank: CTRL (start pulse, IRQ enable), strobed config registers,
// read-only status registers and a write-1-to-clear interrupt status register.
module axil_csr_bank
    import csr_bank_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned NUM_CFG            = 4,
    parameter int unsigned NUM_STAT           = 2
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_CFG*C_S_AXI_DATA_WIDTH-1:0]  cfg_o,
    input  logic [NUM_STAT*C_S_AXI_DATA_WIDTH-1:0] stat_i,
    output logic                                   start_o,
    input  logic                                   done_i,
    output logic                                   irq_o
);

    localparam int unsigned DW             = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW             = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned SW             = DW / 8;
    localparam int unsigned ADDR_LSB       = $clog2(SW);
    localparam int unsigned STAT_BASE_IDX  = stat_base(NUM_CFG);
    localparam int unsigned IRQ_STATUS_IDX = irq_idx(NUM_CFG, NUM_STAT);

    // ---------------------------------------------------------------- write path
    logic [1:0]    wstate_q, wstate_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic [1:0]    bresp_q, bresp_d;

    logic          aw_hs, w_hs, b_hs;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [31:0]   wr_idx;

    assign S_AXI_AWREADY = S_AXI_ARESETN & ((wstate_q == W_IDLE) | (wstate_q == W_HAVE_W));
    assign S_AXI_WREADY  = S_AXI_ARESETN & ((wstate_q == W_IDLE) | (wstate_q == W_HAVE_AW));
    assign S_AXI_BVALID  = (wstate_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign b_hs  = S_AXI_BVALID & S_AXI_BREADY;

    // Address and data may arrive in either order; whichever comes first is parked.
    always_comb begin
        wstate_d = wstate_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        wr_en    = 1'b0;
        wr_addr  = S_AXI_AWADDR;
        wr_data  = S_AXI_WDATA;
        wr_strb  = S_AXI_WSTRB;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_en    = 1'b1;
                    wstate_d = W_RESP;
                end else if (aw_hs) begin
                    awaddr_d = S_AXI_AWADDR;
                    wstate_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                    wstate_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                wr_addr = awaddr_q;
                if (w_hs) begin
                    wr_en    = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_HAVE_W: begin
                wr_data = wdata_q;
                wr_strb = wstrb_q;
                if (aw_hs) begin
                    wr_en    = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    assign wr_idx  = 32'(wr_addr[AW-1:ADDR_LSB]);
    assign bresp_d = !wr_en ? bresp_q :
                     (wr_idx <= IRQ_STATUS_IDX) ? RESP_OKAY : RESP_SLVERR;

    // ---------------------------------------------------------------- registers
    logic [DW-1:0] cfg_q [NUM_CFG];
    logic          irq_en_q, irq_en_d;
    logic          irq_q, irq_d;
    logic          start_pend_q, start_pend_d;
    logic          start_q, start_d;
    logic          ctrl_wr, irq_w1c;

    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
        logic cfg_we;
        assign cfg_we = wr_en && (wr_idx == 32'(CFG_BASE + k));

        csr_strb_reg #(
            .DataWidth(DW)
        ) u_cfg_reg (
            .clk_i (S_AXI_ACLK),
            .rst_ni(S_AXI_ARESETN),
            .we_i  (cfg_we),
            .strb_i(wr_strb),
            .d_i   (wr_data),
            .q_o   (cfg_q[k])
        );

        assign cfg_o[k*DW +: DW] = cfg_q[k];
    end

    assign ctrl_wr = wr_en && (wr_idx == 32'(CTRL_IDX)) && wr_strb[0];
    assign irq_w1c = wr_en && (wr_idx == IRQ_STATUS_IDX) && wr_strb[0] && wr_data[0];

    // START is remembered until the response is accepted, then fires for one cycle.
    always_comb begin
        irq_en_d     = ctrl_wr ? wr_data[CTRL_IRQ_EN_BIT] : irq_en_q;
        start_pend_d = start_pend_q;
        if (ctrl_wr && wr_data[CTRL_START_BIT]) begin
            start_pend_d = 1'b1;
        end else if (b_hs) begin
            start_pend_d = 1'b0;
        end
        start_d = b_hs & start_pend_q;
        // A done strobe beats a simultaneous clear so no completion is lost.
        irq_d = done_i ? 1'b1 : (irq_w1c ? 1'b0 : irq_q);
    end

    assign start_o = start_q;
    assign irq_o   = irq_q & irq_en_q;

    // ---------------------------------------------------------------- read path
    logic [0:0]    rstate_q, rstate_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          ar_hs;
    logic [31:0]   rd_idx;
    logic [DW-1:0] rd_val;
    logic [1:0]    rd_resp;

    assign S_AXI_ARREADY = S_AXI_ARESETN & (rstate_q == R_IDLE);
    assign S_AXI_RVALID  = (rstate_q == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign rd_idx = 32'(S_AXI_ARADDR[AW-1:ADDR_LSB]);

    always_comb begin
        rd_val  = '0;
        rd_resp = (rd_idx <= IRQ_STATUS_IDX) ? RESP_OKAY : RESP_SLVERR;
        if (rd_idx == 32'(CTRL_IDX)) begin
            rd_val[CTRL_IRQ_EN_BIT] = irq_en_q;
        end
        for (int unsigned k = 0; k < NUM_CFG; k++) begin
            if (rd_idx == 32'(CFG_BASE + k)) begin
                rd_val = cfg_q[k];
            end
        end
        for (int unsigned k = 0; k < NUM_STAT; k++) begin
            if (rd_idx == 32'(STAT_BASE_IDX + k)) begin
                rd_val = stat_i[k*DW +: DW];
            end
        end
        if (rd_idx == IRQ_STATUS_IDX) begin
            rd_val[0] = irq_q;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rstate_q == R_IDLE) begin
            if (ar_hs) begin
                rdata_d  = rd_val;
                rresp_d  = rd_resp;
                rstate_d = R_DATA;
            end
        end else if (S_AXI_RREADY) begin
            rstate_d = R_IDLE;
        end
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate_q     <= W_IDLE;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bresp_q      <= RESP_OKAY;
            irq_en_q     <= 1'b0;
            irq_q        <= 1'b0;
            start_pend_q <= 1'b0;
            start_q      <= 1'b0;
            rstate_q     <= R_IDLE;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
        end else begin
            wstate_q     <= wstate_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bresp_q      <= bresp_d;
            irq_en_q     <= irq_en_d;
            irq_q        <= irq_d;
            start_pend_q <= start_pend_d;
            start_q      <= start_d;
            rstate_q     <= rstate_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[ADDR_LSB-1:0],
                           S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axil_csr_bank.sv
// Randomised bench for axil_csr_bank against a register-map level reference model.
module tb_axil_csr_bank;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int NC    = 4;
    localparam int NS    = 2;
    localparam int IRQ_I = 1 + NC + NS;

    logic              clk = 1'b0;
    logic              arstn = 1'b0;
    logic [AW-1:0]     awaddr = '0, araddr = '0;
    logic [2:0]        awprot = '0, arprot = '0;
    logic              awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic              bready = 1'b1, rready = 1'b1;
    logic [DW-1:0]     wdata = '0;
    logic [DW/8-1:0]   wstrb = '0;
    logic              awready, wready, bvalid, arready, rvalid;
    logic [1:0]        bresp, rresp;
    logic [DW-1:0]     rdata;
    logic [NC*DW-1:0]  cfg_o;
    logic [NS*DW-1:0]  stat_i;
    logic              start_o, irq_o;
    logic              done_i = 1'b0;

    logic [31:0] stat_m [NS];
    logic [31:0] m_cfg  [NC];
    logic        m_irq_en, m_irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign stat_i = {stat_m[1], stat_m[0]};

    axil_csr_bank #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_CFG           (NC),
        .NUM_STAT          (NS)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(arstn),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .cfg_o        (cfg_o),
        .stat_i       (stat_i),
        .start_o      (start_o),
        .done_i       (done_i),
        .irq_o        (irq_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) m_cfg[k] = '0;
        m_irq_en = 1'b0;
        m_irq    = 1'b0;
    endtask

    task automatic model_read(input int idx, output logic [31:0] data, output logic [1:0] resp);
        data = '0;
        resp = 2'b00;
        if (idx == 0)                       data = {30'd0, m_irq_en, 1'b0};
        else if (idx <= NC)                 data = m_cfg[idx-1];
        else if (idx <= NC + NS)            data = stat_m[idx-NC-1];
        else if (idx == IRQ_I)              data = {31'd0, m_irq};
        else                                resp = 2'b10;
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < NC; k++)
            check_eq($sformatf("%s cfg_o[%0d]", tag, k), 64'(cfg_o[k*DW +: DW]), 64'(m_cfg[k]));
        check_eq({tag, " irq_o"}, 64'(irq_o), 64'(m_irq & m_irq_en));
    endtask

    // Returns one cycle after the B handshake edge.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input bit done_hs, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge clk);
            awvalid = !aw_done && cyc >= aw_dly;
            awaddr  = addr;
            awprot  = 3'($urandom);
            wvalid  = !w_done && cyc >= w_dly;
            wdata   = data;
            wstrb   = strb;
            #1;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            if (done_hs && (aw_done || aw_hs) && (w_done || w_hs)) done_i = 1'b1;
            @(posedge clk);
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            cyc++;
        end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        done_i  = 1'b0;
        check_eq("aw_w_accepted", 64'({aw_done, w_done}), 64'(2'b11));
        cyc = 0;
        while (!bvalid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("b_latency", 64'(cyc), 64'd0);
        resp = bresp;
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit got = 0;
        int cyc = 0;
        while (!got && cyc < 50) begin
            @(negedge clk);
            arvalid = 1'b1;
            araddr  = addr;
            arprot  = 3'($urandom);
            #1;
            got = arready;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        check_eq("r_latency", 64'(rvalid), 64'd1);
        data = rdata;
        resp = rresp;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int awd, input int wd,
                            input bit done_hs);
        int idx = int'(addr[AW-1:2]);
        logic [1:0] resp;
        logic [1:0] exp_resp = (idx <= IRQ_I) ? 2'b00 : 2'b10;
        bit exp_start = 0;
        axi_write(addr, data, strb, awd, wd, done_hs, resp);
        if (idx == 0 && strb[0]) begin
            m_irq_en  = data[1];
            exp_start = data[0];
        end
        if (idx >= 1 && idx <= NC)
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_cfg[idx-1][b*8 +: 8] = data[b*8 +: 8];
        if (idx == IRQ_I && strb[0] && data[0]) m_irq = 1'b0;
        if (done_hs) m_irq = 1'b1;
        check_eq($sformatf("bresp idx%0d", idx), 64'(resp), 64'(exp_resp));
        check_eq("start_o pulse", 64'(start_o), 64'(exp_start));
        check_state("after write");
        if (exp_start) begin
            @(negedge clk);
            check_eq("start_o single cycle", 64'(start_o), 64'd0);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, output logic [31:0] data);
        int idx = int'(addr[AW-1:2]);
        logic [31:0] exp_d;
        logic [1:0]  exp_r, resp;
        model_read(idx, exp_d, exp_r);
        axi_read(addr, data, resp);
        check_eq($sformatf("rdata idx%0d", idx), 64'(data), 64'(exp_d));
        check_eq($sformatf("rresp idx%0d", idx), 64'(resp), 64'(exp_r));
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        m_irq  = 1'b1;
        check_state("after done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, exp_d;
        logic [1:0]  exp_r;
        model_reset();
        stat_m[0] = 32'h5A5A_0001;
        stat_m[1] = 32'hC0DE_0002;

        // Reset state
        #1;
        check_eq("rst awready", 64'(awready), 64'd0);
        check_eq("rst wready", 64'(wready), 64'd0);
        check_eq("rst arready", 64'(arready), 64'd0);
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        #1;
        check_eq("rel awready", 64'(awready), 64'd1);
        check_eq("rel wready", 64'(wready), 64'd1);
        check_eq("rel arready", 64'(arready), 64'd1);
        check_eq("rst bvalid", 64'(bvalid), 64'd0);
        check_eq("rst rvalid", 64'(rvalid), 64'd0);
        check_eq("rst bresp", 64'(bresp), 64'd0);
        check_eq("rst rresp", 64'(rresp), 64'd0);
        check_eq("rst rdata", 64'(rdata), 64'd0);
        check_eq("rst start_o", 64'(start_o), 64'd0);
        check_state("reset");

        // Config write/readback
        for (int k = 0; k < NC; k++) do_write(6'(4 * (k + 1)), 32'(k + 1), 4'hF, 0, 0, 0);
        for (int k = 0; k < NC; k++) do_read(6'(4 * (k + 1)), rd);

        // Byte strobes
        do_write(6'h04, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
        do_write(6'h04, 32'h1122_3344, 4'b0101, 0, 0, 0);
        do_read(6'h04, rd);
        check_eq("strb merge", 64'(rd), 64'h0000_0000_AA22_CC44);

        // CTRL start pulse, W lagging AW by 3 cycles, then AW lagging W
        do_write(6'h00, 32'h3, 4'hF, 0, 3, 0);
        do_read(6'h00, rd);
        check_eq("ctrl readback", 64'(rd), 64'd2);
        do_write(6'h00, 32'h2, 4'hF, 3, 0, 0);

        // Interrupts: set, set-beats-clear, clear
        pulse_done();
        check_eq("irq raised", 64'(irq_o), 64'd1);
        do_write(6'(4 * IRQ_I), 32'h1, 4'hF, 0, 0, 1);
        check_eq("irq set wins", 64'(irq_o), 64'd1);
        do_write(6'(4 * IRQ_I), 32'h1, 4'hF, 1, 0, 0);
        check_eq("irq cleared", 64'(irq_o), 64'd0);
        do_read(6'(4 * IRQ_I), rd);

        // Unmapped and read-only targets
        do_write(6'(4 * (IRQ_I + 1)), 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_read(6'(4 * (IRQ_I + 1)), rd);
        do_write(6'(4 * (NC + 1)), 32'h0000_FFFF, 4'hF, 0, 0, 0);
        do_read(6'(4 * (NC + 1)), rd);
        do_read(6'(4 * (NC + 2)), rd);

        // RDATA held under backpressure while the source changes
        rready = 1'b0;
        model_read(NC + 1, exp_d, exp_r);
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = 6'(4 * (NC + 1));
        #1;
        check_eq("hold arready", 64'(arready), 64'd1);
        @(negedge clk);
        arvalid   = 1'b0;
        stat_m[0] = ~stat_m[0];
        for (int i = 0; i < 5; i++) begin
            check_eq("hold rvalid", 64'(rvalid), 64'd1);
            check_eq("hold rdata", 64'(rdata), 64'(exp_d));
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        check_eq("hold released", 64'(rvalid), 64'd0);

        // Asynchronous reset while a response is pending
        bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b1;
        wvalid  = 1'b1;
        awaddr  = 6'h08;
        wdata   = 32'hDEAD_BEEF;
        wstrb   = 4'hF;
        @(negedge clk);
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        m_cfg[1] = 32'hDEAD_BEEF;
        check_eq("pre-reset bvalid", 64'(bvalid), 64'd1);
        check_state("pre-reset");
        #2 arstn = 1'b0;
        #1;
        model_reset();
        check_eq("async bvalid", 64'(bvalid), 64'd0);
        check_eq("async awready", 64'(awready), 64'd0);
        check_state("async reset");
        @(negedge clk);
        arstn  = 1'b1;
        bready = 1'b1;
        do_write(6'h0C, 32'h1234_5678, 4'hF, 0, 0, 0);
        do_read(6'h0C, rd);

        // Randomised traffic
        for (int it = 0; it < 150; it++) begin
            int op = $urandom_range(0, 9);
            stat_m[0] = $urandom;
            stat_m[1] = $urandom;
            if (op < 5) begin
                do_write(6'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 7) == 0);
            end else if (op < 9) begin
                do_read(6'($urandom), rd);
            end else begin
                pulse_done();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
